instruction_fetch_unit: RTL and testbench

- Fetch-stage initiator for the instruction memory. It owns the fetch PC, drives the byte address to the combinational instruction memory, and captures the returned word.
- It resolves J-type jumps locally. It buffers fetched words in a small queue that drains to decode through a valid/ready handshake.
- It accepts branch redirects from a later pipeline stage, which flush the queue.

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives fetch_pc to a combinational imem, resolves J-type jumps, and queues {instr, pc} for decode.
// Latency: a word fetched in cycle N heads the queue in N+1. Backpressure: fetch holds its PC while the queue is full and nothing drains.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] stall_count
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      stall_count_q, stall_count_d;
  logic [31:0]      q_instr_q [QUEUE_DEPTH];
  logic [31:0]      q_instr_d [QUEUE_DEPTH];
  logic [31:0]      q_pc_q    [QUEUE_DEPTH];
  logic [31:0]      q_pc_d    [QUEUE_DEPTH];

  logic        dq;
  logic        enq;
  logic        is_jump;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_aligned;

  assign imem_address     = fetch_pc_q;
  assign if_valid         = (count_q != '0);
  assign if_instruction   = q_instr_q[head_q];
  assign if_pc            = q_pc_q[head_q];
  assign if_pc_plus4      = q_pc_q[head_q] + 32'd4;
  assign stall_count      = stall_count_q;

  assign dq               = if_valid & id_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign enq              = ~redirect_valid & ((count_q < DEPTH_C) | dq);
  assign pc_plus4         = fetch_pc_q + 32'd4;
  assign is_jump          = (imem_instruction[31:26] == JUMP_OPCODE);
  assign jump_target      = {pc_plus4[31:28], imem_instruction[25:0], 2'b00};
  assign redirect_aligned = redirect_target & ~32'h0000_0003;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    stall_count_d = stall_count_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
    end else if (enq && is_jump) begin
      fetch_pc_d = jump_target;
    end else if (enq) begin
      fetch_pc_d = pc_plus4;
    end

    if (enq) begin
      q_instr_d[tail_q] = imem_instruction;
      q_pc_d[tail_q]    = fetch_pc_q;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (dq) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(dq);

    // Redirect wins over any same-cycle dequeue: the whole queue is dropped.
    if (redirect_valid) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end

    if ((count_q == DEPTH_C) && !dq && !redirect_valid && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      stall_count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      stall_count_q <= stall_count_d;
      q_instr_q     <= q_instr_d;
      q_pc_q        <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector table for instruction_fetch_unit plus a randomised in-order delivery sequence.
// The bench models the instruction memory and all expected head/PC/stall values.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .id_ready         (id_ready),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .stall_count      (stall_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0800_0004;
      32'h0FFF_FFFC: mem_word = 32'h0800_0003;
      default:       mem_word = 32'hA000_0000 | {4'h0, a[27:0]};
    endcase
  endfunction

  always_comb imem_instruction = mem_word(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        chk;
    logic        ev;
    logic        chkh;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eaddr;
    logic [31:0] estall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt,
                     input logic chk, input logic ev, input logic chkh, input logic [31:0] epc,
                     input logic [31:0] ein, input logic [31:0] eaddr, input logic [31:0] estall);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rt = rt;
    v.chk = chk; v.ev = ev; v.chkh = chkh; v.epc = epc;
    v.ein = ein; v.eaddr = eaddr; v.estall = estall;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int delivered;

    // Reset, then jump at 0 lands on 16 with no gap.
    add(1, 0, 0, 0,    0, 0, 0, 0,  0,            0,  0);
    add(0, 1, 0, 0,    1, 0, 1, 0,  32'h0,        0,  0);
    add(0, 1, 0, 0,    1, 1, 1, 0,  32'h0800_0004, 16, 0);
    // Backpressure for 5 cycles: fills to 2, fetch PC holds at 24, stall counts full cycles.
    add(0, 0, 0, 0,    1, 1, 1, 16, mem_word(16), 20, 0);
    add(0, 0, 0, 0,    1, 1, 1, 16, mem_word(16), 24, 0);
    add(0, 0, 0, 0,    1, 1, 1, 16, mem_word(16), 24, 1);
    add(0, 0, 0, 0,    1, 1, 1, 16, mem_word(16), 24, 2);
    add(0, 0, 0, 0,    1, 1, 1, 16, mem_word(16), 24, 3);
    // Full queue drained and refilled each cycle: stall count frozen at 4.
    add(0, 1, 0, 0,    1, 1, 1, 16, mem_word(16), 24, 4);
    add(0, 1, 0, 0,    1, 1, 1, 20, mem_word(20), 28, 4);
    for (int k = 10; k <= 18; k++) begin
      add(0, 1, 0, 0,  1, 1, 1, 32'(24 + 4 * (k - 10)), mem_word(32'(24 + 4 * (k - 10))),
          32'(32 + 4 * (k - 10)), 4);
    end
    // Queue holds 60,64; redirect to 72 flushes them.
    add(0, 0, 1, 72,   1, 1, 1, 60, mem_word(60), 68, 4);
    add(0, 1, 0, 0,    1, 0, 0, 0,  0,            72, 4);
    add(0, 1, 0, 0,    1, 1, 1, 72, mem_word(72), 76, 4);
    // Misaligned redirect with a same-cycle dequeue.
    add(0, 1, 1, 32'h4E, 1, 1, 1, 76, mem_word(76), 80, 4);
    add(0, 1, 0, 0,    1, 0, 0, 0,  0,            32'h4C, 4);
    add(0, 0, 0, 0,    1, 1, 1, 32'h4C, mem_word(32'h4C), 32'h50, 4);
    add(0, 0, 0, 0,    1, 1, 1, 32'h4C, mem_word(32'h4C), 32'h54, 4);
    // Reset with a full queue and a concurrent redirect.
    add(1, 0, 1, 32'h100, 1, 1, 1, 32'h4C, mem_word(32'h4C), 32'h54, 5);
    add(0, 0, 0, 0,    1, 0, 1, 0,  32'h0,        0,  0);
    // Jump whose region bits come from pc+4, not pc.
    add(0, 1, 1, 32'h0FFF_FFFC, 1, 1, 1, 0, 32'h0800_0004, 16, 0);
    add(0, 1, 0, 0,    1, 0, 0, 0,  0,            32'h0FFF_FFFC, 0);
    add(0, 1, 0, 0,    1, 1, 1, 32'h0FFF_FFFC, 32'h0800_0003, 32'h1000_000C, 0);
    // Sequential PC wrap at the top of the address space.
    add(0, 1, 1, 32'hFFFF_FFFC, 1, 1, 1, 32'h1000_000C, mem_word(32'h1000_000C), 32'h1000_0010, 0);
    add(0, 1, 0, 0,    1, 0, 0, 0,  0,            32'hFFFF_FFFC, 0);
    add(0, 1, 0, 0,    1, 1, 1, 32'hFFFF_FFFC, 32'hAFFF_FFFC, 32'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      cyc = i;
      reset           = vecs[i].rst;
      id_ready        = vecs[i].rdy;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      #1;
      if (vecs[i].chk) begin
        check("if_valid", {31'h0, if_valid}, {31'h0, vecs[i].ev});
        check("imem_address", imem_address, vecs[i].eaddr);
        check("stall_count", stall_count, vecs[i].estall);
        if (vecs[i].chkh) begin
          check("if_pc", if_pc, vecs[i].epc);
          check("if_instruction", if_instruction, vecs[i].ein);
          check("if_pc_plus4", if_pc_plus4, vecs[i].epc + 32'd4);
        end
      end
    end

    // Random decode backpressure: every PC delivered exactly once, in order.
    @(negedge clock);
    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 32'h0;
    delivered = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      cyc = 1000 + n;
      id_ready = 1'($urandom_range(0, 1));
      #1;
      if (if_valid && id_ready) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_instr", if_instruction, mem_word(exp_pc));
        exp_pc = (exp_pc == 32'h0) ? 32'd16 : exp_pc + 32'd4;
        delivered++;
      end
    end
    check("stream_progress", {31'h0, (delivered > 50)}, 32'h1);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
